// File: rtl/imu_axil_pkg.sv
// Shared definitions for the IMU AXI4-Lite register file.
// Holds register offsets, response codes and the sample type.
// Also provides small helpers for address decode and sign extension.
package imu_axil_pkg;

  // Byte offsets of the eight 32-bit words
  localparam logic [4:0] REG0       = 5'h00;
  localparam logic [4:0] REG1       = 5'h04;
  localparam logic [4:0] REG2       = 5'h08;
  localparam logic [4:0] REG3       = 5'h0C;
  localparam logic [4:0] ACC_X      = 5'h10;
  localparam logic [4:0] ACC_Y      = 5'h14;
  localparam logic [4:0] ACC_Z      = 5'h18;
  localparam logic [4:0] SAMPLE_CNT = 5'h1C;

  localparam int ADDR_LSB   = 2;
  localparam int WORD_IDX_W = 3;

  // Word indices derived from the byte offsets
  localparam logic [WORD_IDX_W-1:0] IDX_REG0       = REG0[4:2];
  localparam logic [WORD_IDX_W-1:0] IDX_REG1       = REG1[4:2];
  localparam logic [WORD_IDX_W-1:0] IDX_REG2       = REG2[4:2];
  localparam logic [WORD_IDX_W-1:0] IDX_REG3       = REG3[4:2];
  localparam logic [WORD_IDX_W-1:0] IDX_ACC_X      = ACC_X[4:2];
  localparam logic [WORD_IDX_W-1:0] IDX_ACC_Y      = ACC_Y[4:2];
  localparam logic [WORD_IDX_W-1:0] IDX_ACC_Z      = ACC_Z[4:2];
  localparam logic [WORD_IDX_W-1:0] IDX_SAMPLE_CNT = SAMPLE_CNT[4:2];

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef logic signed [15:0] imu_sample_t;

  // Word index of a byte address; the two byte-lane bits are ignored
  function automatic logic [WORD_IDX_W-1:0] word_idx(input logic [4:0] byte_addr);
    return byte_addr[ADDR_LSB +: WORD_IDX_W];
  endfunction

  // Upper half of the map (0x10..0x1C) is read-only
  function automatic logic is_ro_word(input logic [WORD_IDX_W-1:0] idx);
    return idx[WORD_IDX_W-1];
  endfunction

  function automatic logic [31:0] sext_sample(input imu_sample_t s);
    return {{16{s[15]}}, s};
  endfunction

endpackage

// File: rtl/imu_axil_regs.sv
// AXI4-Lite slave: four RW config words plus IMU sample words with coherent snapshot.
// Latency: write response one edge after both AW and W held; read data the edge after AR.
// Backpressure: one AW and one W are held while BVALID waits; ARREADY low while RVALID.
module imu_axil_regs
  import imu_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            imu_valid,
  input  imu_sample_t                     imu_ax,
  input  imu_sample_t                     imu_ay,
  input  imu_sample_t                     imu_az,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg3
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  // Ready outputs stay low until the first edge after reset release
  logic                          r_out_of_reset;

  // Write-side holding registers
  logic                          r_aw_full;
  logic [WORD_IDX_W-1:0]         r_aw_idx;
  logic                          r_w_full;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]             r_wstrb;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;

  // Read-side registers
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

  // Register file contents
  logic [C_S_AXI_DATA_WIDTH-1:0] r_cfg [4];
  imu_sample_t                   r_live_ax;
  imu_sample_t                   r_live_ay;
  imu_sample_t                   r_live_az;
  imu_sample_t                   r_snap_ay;
  imu_sample_t                   r_snap_az;
  logic [31:0]                   r_sample_cnt;

  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_ar_hs;
  logic                          w_commit;
  logic                          w_commit_ro;
  logic [WORD_IDX_W-1:0]         w_ar_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rdata_mux;
  logic                          w_unused;

  assign S_AXI_AWREADY = r_out_of_reset && !r_aw_full;
  assign S_AXI_WREADY  = r_out_of_reset && !r_w_full;
  assign S_AXI_ARREADY = r_out_of_reset && !r_rvalid;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = AXI_RESP_OKAY;

  assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_ar_idx = word_idx(S_AXI_ARADDR);

  // A held address/data pair retires once the response slot is free
  assign w_commit    = r_aw_full && r_w_full && (!r_bvalid || S_AXI_BREADY);
  assign w_commit_ro = is_ro_word(r_aw_idx);

  assign cfg_reg0 = r_cfg[0];
  assign cfg_reg1 = r_cfg[1];
  assign cfg_reg2 = r_cfg[2];
  assign cfg_reg3 = r_cfg[3];

  // Protection bits and byte-lane address bits carry no meaning here
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Arm the ready outputs one edge after reset is released
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_out_of_reset <= 1'b0;
    end else begin
      r_out_of_reset <= 1'b1;
    end
  end

  // Write FSM: capture AW and W independently, retire them together into BVALID
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= word_idx(S_AXI_AWADDR);
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end
      // Handshakes need an empty flag and commit needs both full, so they never collide
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_commit_ro ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Config registers: byte-masked update at commit, read-only targets ignored
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        r_cfg[i] <= '0;
      end
    end else if (w_commit && !w_commit_ro) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (r_wstrb[b]) begin
          r_cfg[r_aw_idx[1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data select from current (pre-update) register values
  always_comb begin
    w_rdata_mux = '0;
    case (w_ar_idx)
      IDX_REG0:       w_rdata_mux = r_cfg[0];
      IDX_REG1:       w_rdata_mux = r_cfg[1];
      IDX_REG2:       w_rdata_mux = r_cfg[2];
      IDX_REG3:       w_rdata_mux = r_cfg[3];
      IDX_ACC_X:      w_rdata_mux = sext_sample(r_live_ax);
      IDX_ACC_Y:      w_rdata_mux = sext_sample(r_snap_ay);
      IDX_ACC_Z:      w_rdata_mux = sext_sample(r_snap_az);
      IDX_SAMPLE_CNT: w_rdata_mux = r_sample_cnt;
      default:        w_rdata_mux = '0;
    endcase
  end

  // Read FSM: register data on AR handshake, hold until RREADY
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata_mux;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Live sample capture and sample counter
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_live_ax    <= '0;
      r_live_ay    <= '0;
      r_live_az    <= '0;
      r_sample_cnt <= '0;
    end else if (imu_valid) begin
      r_live_ax    <= imu_ax;
      r_live_ay    <= imu_ay;
      r_live_az    <= imu_az;
      r_sample_cnt <= r_sample_cnt + 32'd1;
    end
  end

  // Reading ACC_X freezes Y/Z from the same (pre-update) sample as the returned X
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_snap_ay <= '0;
      r_snap_az <= '0;
    end else if (w_ar_hs && (w_ar_idx == IDX_ACC_X)) begin
      r_snap_ay <= r_live_ay;
      r_snap_az <= r_live_az;
    end
  end

endmodule

// File: tb/tb_imu_axil_regs.sv
// Scoreboard bench for imu_axil_regs: expected B/R responses are queued at issue
// and popped by a monitor at each handshake; direct checks cover reset, stall
// behaviour, coherency corner cases and asynchronous reset.
module tb_imu_axil_regs;
  import imu_axil_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [4:0]  addr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        imu_valid;
  imu_sample_t imu_ax;
  imu_sample_t imu_ay;
  imu_sample_t imu_az;
  logic [31:0] cfg_reg0;
  logic [31:0] cfg_reg1;
  logic [31:0] cfg_reg2;
  logic [31:0] cfg_reg3;

  exp_t bq[$];
  exp_t rq[$];
  int   errors = 0;
  int   checks = 0;

  imu_axil_regs dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .imu_valid    (imu_valid),
    .imu_ax       (imu_ax),
    .imu_ay       (imu_ay),
    .imu_az       (imu_az),
    .cfg_reg0     (cfg_reg0),
    .cfg_reg1     (cfg_reg1),
    .cfg_reg2     (cfg_reg2),
    .cfg_reg3     (cfg_reg3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: no response within cycle budget", nm);
  endtask

  // Monitor: one pop per handshake (valid && ready seen before the edge)
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          timeout_fail("b_unexpected");
        end else begin
          e = bq.pop_front();
          chk($sformatf("bresp@%02h", e.addr), {30'd0, bresp}, {30'd0, e.resp});
        end
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          timeout_fail("r_unexpected");
        end else begin
          e = rq.pop_front();
          chk($sformatf("rdata@%02h", e.addr), rdata, e.data);
          chk($sformatf("rresp@%02h", e.addr), {30'd0, rresp}, {30'd0, e.resp});
        end
      end
    end
  end

  // All driver tasks enter and leave 1 time unit after a rising edge
  task automatic send_aw(input logic [4:0] a, input int dly);
    bit done = 0;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr  = a;
    awvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (awready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    awvalid = 1'b0;
    if (!done) timeout_fail("aw_handshake");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit done = 0;
    repeat (dly) begin @(posedge clk); #1; end
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (wready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    wvalid = 1'b0;
    if (!done) timeout_fail("w_handshake");
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] r, input int aw_dly, input int w_dly);
    exp_t e;
    e.data = d;
    e.resp = r;
    e.addr = a;
    bq.push_back(e);
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] d, input bit track);
    exp_t e;
    bit   done = 0;
    e.data = d;
    e.resp = AXI_RESP_OKAY;
    e.addr = a;
    if (track) rq.push_back(e);
    araddr  = a;
    arvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (arready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    arvalid = 1'b0;
    if (!done) timeout_fail("ar_handshake");
  endtask

  task automatic sample(input imu_sample_t x, input imu_sample_t y, input imu_sample_t z);
    imu_ax    = x;
    imu_ay    = y;
    imu_az    = z;
    imu_valid = 1'b1;
    @(posedge clk); #1;
    imu_valid = 1'b0;
  endtask

  // AR handshake forced into the same edge as an imu_valid strobe
  task automatic coinc_read(input logic [4:0] a, input logic [31:0] d,
                            input imu_sample_t x, input imu_sample_t y, input imu_sample_t z);
    exp_t e;
    e.data = d;
    e.resp = AXI_RESP_OKAY;
    e.addr = a;
    rq.push_back(e);
    araddr    = a;
    arvalid   = 1'b1;
    imu_ax    = x;
    imu_ay    = y;
    imu_az    = z;
    imu_valid = 1'b1;
    @(negedge clk);
    chk("coinc_arready", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid   = 1'b0;
    imu_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      if (bq.size() == 0 && rq.size() == 0 && !bvalid && !rvalid) idle = 1;
    end
    if (!idle) timeout_fail("idle_wait");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    imu_valid = 1'b0; imu_ax = '0; imu_ay = '0; imu_az = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    chk("rst_cfg0",    cfg_reg0,         32'd0);
    chk("rst_cfg3",    cfg_reg3,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_awready", {31'd0, awready}, 32'd1);
    chk("rel_wready",  {31'd0, wready},  32'd1);
    chk("rel_arready", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;

    // Basic write and read-back of the RW words
    for (int i = 0; i < 4; i++) axi_write(5'(4 * i), 32'(i + 1), 4'hF, AXI_RESP_OKAY, 0, 0);
    wait_idle();
    chk("cfg0_out", cfg_reg0, 32'h1);
    chk("cfg1_out", cfg_reg1, 32'h2);
    chk("cfg2_out", cfg_reg2, 32'h3);
    chk("cfg3_out", cfg_reg3, 32'h4);
    for (int i = 0; i < 4; i++) axi_read(5'(4 * i), 32'(i + 1), 1);
    wait_idle();

    // W three cycles ahead of AW, partial strobe over zero
    axi_write(5'h04, 32'h0, 4'hF, AXI_RESP_OKAY, 0, 0);
    wait_idle();
    axi_write(5'h04, 32'hDEADBEEF, 4'b0101, AXI_RESP_OKAY, 3, 0);
    wait_idle();
    chk("strb_cfg1", cfg_reg1, 32'h00AD00EF);
    axi_read(5'h04, 32'h00AD00EF, 1);
    wait_idle();

    // Response back-pressure
    bready = 1'b0;
    axi_write(5'h08, 32'hA5A5A5A5, 4'hF, AXI_RESP_OKAY, 0, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bvalid) seen = 1;
    end
    if (!seen) timeout_fail("bp_bvalid");
    chk("bp_cfg2", cfg_reg2, 32'hA5A5A5A5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_bvalid_%0d", i), {31'd0, bvalid}, 32'd1);
      chk($sformatf("bp_bresp_%0d", i),  {30'd0, bresp},  32'd0);
    end
    @(posedge clk); #1;
    axi_write(5'h0C, 32'h12340000, 4'hF, AXI_RESP_OKAY, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_awready_%0d", i), {31'd0, awready}, 32'd0);
      chk($sformatf("bp_wready_%0d", i),  {31'd0, wready},  32'd0);
    end
    chk("bp_cfg3_held", cfg_reg3, 32'h4);
    @(posedge clk); #1;
    bready = 1'b1;
    wait_idle();
    chk("bp_cfg3_new", cfg_reg3, 32'h12340000);

    // Write to a read-only word
    axi_write(5'h10, 32'h12345678, 4'hF, AXI_RESP_SLVERR, 0, 0);
    wait_idle();
    axi_read(5'h10, 32'h0, 1);
    wait_idle();

    // Samples and snapshot coherency
    sample(-16'sd2, 16'sd5, 16'sd7);
    axi_read(5'h10, 32'hFFFFFFFE, 1);
    sample(16'sd9, 16'sd9, 16'sd9);
    axi_read(5'h14, 32'd5, 1);
    axi_read(5'h18, 32'd7, 1);
    axi_read(5'h1C, 32'd2, 1);
    wait_idle();
    coinc_read(5'h10, 32'd9, 16'sd100, 16'sd200, 16'sd300);
    axi_read(5'h14, 32'd9, 1);
    axi_read(5'h18, 32'd9, 1);
    axi_read(5'h10, 32'd100, 1);
    axi_read(5'h14, 32'd200, 1);
    axi_read(5'h18, 32'd300, 1);
    wait_idle();
    coinc_read(5'h1C, 32'd3, 16'sd1, 16'sd1, 16'sd1);
    axi_read(5'h1C, 32'd4, 1);
    wait_idle();

    // Asynchronous reset with a read response pending
    rready = 1'b0;
    axi_read(5'h00, 32'h1, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rvalid) seen = 1;
    end
    if (!seen) timeout_fail("ar_pending_rvalid");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("arst_arready", {31'd0, arready}, 32'd0);
    chk("arst_rdata",   rdata,            32'd0);
    chk("arst_cfg0",    cfg_reg0,         32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    rready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 4; i++) axi_read(5'(4 * i), 32'd0, 1);
    axi_read(5'h1C, 32'd0, 1);
    wait_idle();
    chk("arst_cfg3", cfg_reg3, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
